sync_fifo_flags: RTL
====================

# sync_fifo_flags

Parametrised single-clock FIFO that extends the basic synchronous FIFO with programmable almost-full and almost-empty thresholds, an occupancy count, overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It is the general-purpose buffer between producer and consumer datapaths that share one clock domain, and it replaces the fixed-behaviour FIFO wherever back-pressure needs early warning or a zero-latency head-of-queue view.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DATA_DEPTH, 128, number of entries; power of two, ≥4
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through
- AFULL_TH, DATA_DEPTH-4, o_afull asserts when count ≥ AFULL_TH; legal range 1..DATA_DEPTH
- AEMPTY_TH, 4, o_aempty asserts when count ≤ AEMPTY_TH; legal range 0..DATA_DEPTH-1
- Derived: AW = $clog2(DATA_DEPTH), CW = AW+1

- i_sys_clk  in  1  sole clock, all logic on the rising edge
- i_sys_rst  in  1  asynchronous, active-high reset
- i_wren  in  1  write request
- i_wdata  in  DATA_WIDTH  write data, sampled with i_wren
- i_rden  in  1  read request (standard) / pop of the head word (FWFT)
- o_rdata  out  DATA_WIDTH  read data
- o_rvalid  out  1  o_rdata is valid
- o_empty  out  1  count == 0
- o_full  out  1  count == DATA_DEPTH
- o_aempty  out  1  count ≤ AEMPTY_TH
- o_afull  out  1  count ≥ AFULL_TH
- o_count  out  CW  number of stored words, 0..DATA_DEPTH
- o_overflow  out  1  1-cycle pulse: write rejected
- o_underflow  out  1  1-cycle pulse: read rejected

## Operation
- Write accepted iff i_wren && !o_full; word stored at wr_ptr, wr_ptr increments.
- Read accepted iff i_rden && !o_empty; rd_ptr increments.
- Acceptance uses the registered flags only. A write while full is rejected even if a read is accepted in the same cycle; a read while empty is rejected even if a write is accepted in the same cycle.
- Pointers are CW bits wide; the low AW bits address memory and wrap from DATA_DEPTH-1 to 0. The MSB is kept for the full/empty distinction. o_count is a separate registered counter: +1 on write only, −1 on read only, unchanged on both or neither.
- Flags are registered and derived from the next-state count, so they are exact in the cycle after the accepted operation.
- Rejected write: o_overflow = 1 for one cycle; memory, pointers and count are unchanged. Rejected read: o_underflow = 1 for one cycle; state is unchanged. The pulses are independent and may occur in the same cycle.
- Standard mode: o_rdata is a register loaded with mem[rd_ptr] on an accepted read. o_rvalid pulses for one cycle with the data. o_rdata holds its last value otherwise.
- FWFT mode: o_rdata = mem[rd_ptr], driven combinationally from the storage read port, and o_rvalid = !o_empty. An accepted i_rden pops the head, and the next word appears the following cycle.
- Reset: wr_ptr = rd_ptr = 0, o_count = 0, o_empty = 1, o_aempty = 1, o_full = 0, o_afull = 0 (AFULL_TH ≥ 1), o_rdata = 0, o_rvalid = 0, o_overflow = 0, o_underflow = 0. Memory contents are not cleared. A reset mid-operation discards all stored words, and the FIFO is empty on the first edge after release.

## Timing
- Write to flag update: 1 cycle. o_empty falls on the edge after the first accepted write.
- Standard read latency: 1 cycle from the accepted i_rden to o_rdata/o_rvalid.
- FWFT first-word latency: the head word is visible on o_rdata one cycle after it is written into an empty FIFO.
- Full throughput: one write and one read per cycle, sustained.
- Overflow and underflow pulses appear in the cycle after the rejected request.

## Structure
- Shared package fifo_pkg holds the clog2-based width helper and the FWFT mode constants (FIFO_STD = 0, FIFO_FWFT = 1), which other FIFO variants reuse.
- Sub-module fifo_ram: simple dual-port storage with one write port and an asynchronous read port, DATA_WIDTH × DATA_DEPTH.
- The top level holds the pointers, count, flags, error pulses and read-mode muxing.

## Test plan
- Standard mode, DEPTH 128: write 1..128 back-to-back. o_afull rises after the 124th write, o_full and o_count = 128 after the 128th. A 129th write gives a single o_overflow pulse and o_count stays 128.
- Drain the full FIFO with 128 reads. o_rdata = 1..128 in order, each one cycle after its i_rden. o_aempty rises when count = 4, and o_empty at count 0. A 129th read gives an o_underflow pulse, with o_rdata still 128.
- Fill to 64, then hold i_wren and i_rden together for 200 cycles. o_count stays 64, data order is preserved across pointer wrap, and no error pulses occur.
- FWFT = 1: write 0xA5 into an empty FIFO. The next cycle o_empty = 0, o_rvalid = 1, o_rdata = 0xA5. Write 0x5A, then pop: o_rdata = 0x5A the following cycle.
- Full FIFO with simultaneous write and read: the read is accepted, the write is rejected with o_overflow, and o_count = 127.
- Assert i_sys_rst mid-fill at count 37. All outputs take their reset values asynchronously. After release, writing 0x11 and reading it returns 0x11 with no stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and the occupancy-width helper.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 128
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DATA_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(DATA_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a standard or first-word-fall-through read port.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 128,
  parameter int unsigned FWFT       = FIFO_STD,
  parameter int unsigned AFULL_TH   = DATA_DEPTH - 4,
  parameter int unsigned AEMPTY_TH  = 4
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst,
  input  logic                        i_wren,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  input  logic                        i_rden,
  output logic [DATA_WIDTH-1:0]       o_rdata,
  output logic                        o_rvalid,
  output logic                        o_empty,
  output logic                        o_full,
  output logic                        o_aempty,
  output logic                        o_afull,
  output logic [$clog2(DATA_DEPTH):0] o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam int unsigned CW = fifo_cnt_width(DATA_DEPTH);

  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  empty_q;
  logic                  full_q;
  logic                  aempty_q;
  logic                  afull_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Acceptance looks only at the registered flags, never at the same-cycle partner op.
  assign wr_acc = i_wren && !full_q;
  assign rd_acc = i_rden && !empty_q;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count - CW'(1);
  end

  // Pointers, count and flags; flags follow the next-state count.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      count       <= count_nxt;
      empty_q     <= (count_nxt == '0);
      full_q      <= (count_nxt == CW'(DATA_DEPTH));
      aempty_q    <= (count_nxt <= CW'(AEMPTY_TH));
      afull_q     <= (count_nxt >= CW'(AFULL_TH));
      overflow_q  <= i_wren && full_q;
      underflow_q <= i_rden && empty_q;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk   (i_sys_clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (i_wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word shown directly; forced to zero while empty so stale memory never leaks out.
    assign o_rdata  = empty_q ? '0 : ram_rdata;
    assign o_rvalid = !empty_q;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= ram_rdata;
      end
    end

    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;
  end

  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_aempty    = aempty_q;
  assign o_afull     = afull_q;
  assign o_count     = count;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule
